// File: rtl/product_accum.sv
// product_accum: signed 64-bit product accumulator with frame counting,
// optional saturation of the final frame sum and a one-deep result
// register with valid/ready handshake.
module product_accum #(
   parameter int NUM_TERMS = 4,
   parameter int SAT_EN    = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [63:0] Product,
   input  logic        Product_Valid,
   input  logic        Clear,
   output logic [63:0] Sum,
   output logic        Sum_Valid,
   input  logic        Sum_Ready,
   output logic        Ovf,
   output logic        Drop,
   output logic [3:0]  Term_Cnt
);

   localparam logic [3:0] TERMS_C = 4'(NUM_TERMS);
   localparam logic       SAT_C   = (SAT_EN != 0);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   // True when the 68-bit value is representable as a signed 64-bit value:
   // the top five bits must all equal the 64-bit sign bit.
   function automatic logic fits_64(input logic [67:0] v);
      return (v[67:63] == 5'b00000) || (v[67:63] == 5'b11111);
   endfunction

   // Reduce a 68-bit frame total to 64 bits: exact when it fits, otherwise
   // clamp to the signed extreme of matching sign, or keep the low bits.
   function automatic logic [63:0] reduce_64(input logic [67:0] v, input logic sat);
      logic [63:0] r;
      if (fits_64(v) || !sat) begin
         r = v[63:0];
      end else if (v[67]) begin
         r = 64'h8000_0000_0000_0000;
      end else begin
         r = 64'h7FFF_FFFF_FFFF_FFFF;
      end
      return r;
   endfunction

   state_t      state_r;
   logic [67:0] acc_r;
   logic [3:0]  cnt_r;
   logic [63:0] sum_r;
   logic        sum_valid_r;
   logic        ovf_r;
   logic        drop_r;

   logic        new_frame_s;
   logic [67:0] base_s;
   logic [67:0] total_s;
   logic [3:0]  cnt_next_s;
   logic        complete_s;
   logic        result_ovf_s;
   logic [63:0] result_s;
   logic        load_s;

   // Next accumulator value, term count and frame-completion decode.
   always_comb begin
      new_frame_s  = Clear || (state_r == ST_IDLE);
      base_s       = 68'd0;
      cnt_next_s   = 4'd1;
      if (new_frame_s) begin
         base_s     = 68'd0;
         cnt_next_s = 4'd1;
      end else begin
         base_s     = acc_r;
         cnt_next_s = cnt_r + 4'd1;
      end
      total_s      = base_s + {{4{Product[63]}}, Product};
      complete_s   = Product_Valid && (cnt_next_s == TERMS_C);
      result_ovf_s = !fits_64(total_s);
      result_s     = reduce_64(total_s, SAT_C);
      load_s       = complete_s && (!sum_valid_r || Sum_Ready);
   end

   // Frame FSM: tracks the open frame's accumulator and term count.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= ST_IDLE;
         acc_r   <= 68'd0;
         cnt_r   <= 4'd0;
      end else if (Product_Valid) begin
         if (complete_s) begin
            state_r <= ST_IDLE;
            acc_r   <= 68'd0;
            cnt_r   <= 4'd0;
         end else begin
            state_r <= ST_ACCUM;
            acc_r   <= total_s;
            cnt_r   <= cnt_next_s;
         end
      end else if (Clear) begin
         state_r <= ST_IDLE;
         acc_r   <= 68'd0;
         cnt_r   <= 4'd0;
      end
   end

   // Result register: loads completed frames, holds under backpressure,
   // and records a sticky drop when a result arrives with no room.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sum_r       <= 64'd0;
         sum_valid_r <= 1'b0;
         ovf_r       <= 1'b0;
         drop_r      <= 1'b0;
      end else if (complete_s) begin
         if (load_s) begin
            sum_r       <= result_s;
            ovf_r       <= result_ovf_s;
            sum_valid_r <= 1'b1;
         end else begin
            drop_r      <= 1'b1;
         end
      end else if (sum_valid_r && Sum_Ready) begin
         sum_valid_r <= 1'b0;
      end
   end

   assign Sum       = sum_r;
   assign Sum_Valid = sum_valid_r;
   assign Ovf       = ovf_r;
   assign Drop      = drop_r;
   assign Term_Cnt  = cnt_r;

endmodule
